// File: rtl/data_mem_burst.sv
// data_mem_burst
// Block-granular data memory behind a valid/ready request channel and a
// valid/ready response channel. Used by the data cache for refills and
// write-backs. Only one request is in flight at a time.
//
// Access latency is LATENCY cycles. An acceptance at edge T commits a write,
// or samples a read, at edge T+LATENCY. resp_valid rises right after that edge.
// Block byte i is bits [8i+7:8i] and maps to array[(base+i) mod MEM_BYTES] on
// both the read and the write path. The array itself is never reset.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  block can accept a request (IDLE and not in reset)
//   req_we     in   1 = write block, 0 = read block
//   req_addr   in   byte address; offset bits inside a block are ignored
//   req_wdata  in   write block
//   req_wstrb  in   per-byte write enable
//   resp_valid out  response present (read data or write ack)
//   resp_ready in   consumer accepts the response
//   resp_we    out  echo of req_we for this response
//   resp_rdata out  read block; zero for write responses
module data_mem_burst #(
  parameter int    ADDRESS_WIDTH = 32,
  parameter int    BLOCK_WIDTH   = 128,
  parameter int    MEM_BYTES     = 131072,
  parameter int    LATENCY       = 2,
  parameter string INIT_FILE     = "../rtl/memory/sinerom.mem"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [BLOCK_WIDTH-1:0]     req_wdata,
  input  logic [BLOCK_WIDTH/8-1:0]   req_wstrb,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_we,
  output logic [BLOCK_WIDTH-1:0]     resp_rdata
);

  localparam int NB  = BLOCK_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int MW  = $clog2(MEM_BYTES);
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_cnt;

  logic                   r_we;
  logic [MW-1:0]          r_base;
  logic [BLOCK_WIDTH-1:0] r_wdata;
  logic [NB-1:0]          r_wstrb;

  logic                   r_resp_valid;
  logic                   r_resp_we;
  logic [BLOCK_WIDTH-1:0] r_resp_rdata;

  logic [7:0]             r_mem [MEM_BYTES];

  logic                   w_accept;
  logic                   w_fire;
  logic [MW-1:0]          w_idx [NB];
  logic [BLOCK_WIDTH-1:0] w_rd_block;
  logic                   w_unused_addr;

  // Offset bits and the address bits above the array size are dropped.
  assign w_unused_addr = ^req_addr;

  // req_ready is a pure state decode, forced low while reset is held.
  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept   = req_valid && req_ready;
  // Edge T+LATENCY: the countdown has expired while waiting.
  assign w_fire     = (r_state == S_WAIT) && (r_cnt == {CW{1'b0}}) && !rst;

  assign resp_valid = r_resp_valid;
  assign resp_we    = r_resp_we;
  assign resp_rdata = r_resp_rdata;

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = S_WAIT;
        else           w_next = S_IDLE;
      end
      S_WAIT: begin
        if (r_cnt == {CW{1'b0}}) w_next = S_RESP;
        else                     w_next = S_WAIT;
      end
      S_RESP: begin
        if (resp_ready) w_next = S_IDLE;
        else            w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-byte array indices (wrap modulo MEM_BYTES) and the gathered read block.
  always_comb begin
    w_rd_block = {BLOCK_WIDTH{1'b0}};
    for (int i = 0; i < NB; i++) begin
      w_idx[i]               = r_base + MW'(i);
      w_rd_block[8*i +: 8]   = r_mem[w_idx[i]];
    end
  end

  // State, latency counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CW{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_rdata <= {BLOCK_WIDTH{1'b0}};
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE:  if (req_valid) r_cnt <= CW'(LATENCY - 1);
        S_WAIT:  if (r_cnt != {CW{1'b0}}) r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_fire) begin
        r_resp_valid <= 1'b1;
        r_resp_we    <= r_we;
        r_resp_rdata <= r_we ? {BLOCK_WIDTH{1'b0}} : w_rd_block;
      end else if ((r_state == S_RESP) && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  // Request capture; only meaningful once a request has been accepted.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_base  <= {req_addr[MW-1:OFF], {OFF{1'b0}}};
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  // Strobed write commit; w_fire already excludes a same-edge reset.
  always_ff @(posedge clk) begin
    if (w_fire && r_we) begin
      for (int i = 0; i < NB; i++) begin
        if (r_wstrb[i]) r_mem[w_idx[i]] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_burst.sv
// Directed bench for data_mem_burst. Four instances differ only in LATENCY
// (2, 1, 5, 3). Index k picks the instance's signal set.
module tb_data_mem_burst;

  logic         clk = 1'b0;
  logic         rst      [4];
  logic         rv       [4];
  logic         rr       [4];
  logic         we       [4];
  logic [31:0]  addr     [4];
  logic [127:0] wd       [4];
  logic [15:0]  ws       [4];
  logic         rsp_v    [4];
  logic         rsp_r    [4];
  logic         rsp_we   [4];
  logic [127:0] rsp_d    [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_burst #(.LATENCY(2), .INIT_FILE("")) u_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(we[0]),
    .req_addr(addr[0]), .req_wdata(wd[0]), .req_wstrb(ws[0]), .resp_valid(rsp_v[0]),
    .resp_ready(rsp_r[0]), .resp_we(rsp_we[0]), .resp_rdata(rsp_d[0]));
  data_mem_burst #(.LATENCY(1), .INIT_FILE("")) u_l1 (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(we[1]),
    .req_addr(addr[1]), .req_wdata(wd[1]), .req_wstrb(ws[1]), .resp_valid(rsp_v[1]),
    .resp_ready(rsp_r[1]), .resp_we(rsp_we[1]), .resp_rdata(rsp_d[1]));
  data_mem_burst #(.LATENCY(5), .INIT_FILE("")) u_l5 (
    .clk(clk), .rst(rst[2]), .req_valid(rv[2]), .req_ready(rr[2]), .req_we(we[2]),
    .req_addr(addr[2]), .req_wdata(wd[2]), .req_wstrb(ws[2]), .resp_valid(rsp_v[2]),
    .resp_ready(rsp_r[2]), .resp_we(rsp_we[2]), .resp_rdata(rsp_d[2]));
  data_mem_burst #(.LATENCY(3), .INIT_FILE("")) u_l3 (
    .clk(clk), .rst(rst[3]), .req_valid(rv[3]), .req_ready(rr[3]), .req_we(we[3]),
    .req_addr(addr[3]), .req_wdata(wd[3]), .req_wstrb(ws[3]), .resp_valid(rsp_v[3]),
    .resp_ready(rsp_r[3]), .resp_we(rsp_we[3]), .resp_rdata(rsp_d[3]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with resp_ready held high; checks latency and echo.
  task automatic txn(input int k, input int lat, input logic w, input logic [31:0] a,
                     input logic [127:0] d, input logic [15:0] s, output logic [127:0] rd);
    int n;
    chk("idle_ready", 128'(rr[k]), 128'd1);
    rv[k] = 1'b1; we[k] = w; addr[k] = a; wd[k] = d; ws[k] = s; rsp_r[k] = 1'b1;
    step();
    rv[k] = 1'b0;
    n = 0;
    while (!rsp_v[k] && n < 20) begin
      step();
      n++;
    end
    chk("latency", 128'(n), 128'(lat));
    chk("resp_we", 128'(rsp_we[k]), 128'(w));
    rd = rsp_d[k];
    if (w) chk("wr_rdata_zero", rsp_d[k], 128'd0);
    else   chk("rd_ready_busy", 128'(rr[k]), 128'd0);
    step();
    chk("resp_dropped", 128'(rsp_v[k]), 128'd0);
  endtask

  localparam logic [127:0] P_SEQ  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] P_PART = 128'h0F0E0D0C_0B0A0908_07060504_0302FFFF;
  localparam logic [127:0] P_WRAP = 128'hDEADBEEF_01234567_89ABCDEF_A5A55A5A;
  localparam logic [127:0] P_LAT  = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [127:0] P_OLD  = 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0;
  localparam logic [127:0] P_NEW  = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;

  initial begin
    logic [127:0] rd;
    logic [127:0] held;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; rv[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0;
      wd[k] = 128'd0; ws[k] = 16'd0; rsp_r[k] = 1'b0;
    end

    // Reset held for two edges.
    step();
    chk("rst_ready", 128'(rr[0]), 128'd0);
    chk("rst_valid", 128'(rsp_v[0]), 128'd0);
    chk("rst_rdata", rsp_d[0], 128'd0);
    step();
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    #1;
    chk("post_rst_ready", 128'(rr[0]), 128'd1);
    chk("post_rst_valid", 128'(rsp_v[0]), 128'd0);
    chk("post_rst_rdata", rsp_d[0], 128'd0);

    // Round trip, LATENCY=2; read uses a non-zero offset inside the block.
    txn(0, 2, 1'b1, 32'h0000_0100, P_SEQ, 16'hFFFF, rd);
    txn(0, 2, 1'b0, 32'h0000_010C, 128'd0, 16'h0000, rd);
    chk("rt_block", rd, P_SEQ);
    chk("rt_byte0", 128'(rd[7:0]), 128'h00);
    chk("rt_byte15", 128'(rd[127:120]), 128'h0F);

    // Partial strobe: only bytes 0 and 1 change.
    txn(0, 2, 1'b1, 32'h0000_0100, {128{1'b1}}, 16'h0003, rd);
    txn(0, 2, 1'b0, 32'h0000_0100, 128'd0, 16'h0000, rd);
    chk("partial", rd, P_PART);

    // All-zero strobe still answers and leaves the block intact.
    txn(0, 2, 1'b1, 32'h0000_0100, 128'd0, 16'h0000, rd);
    txn(0, 2, 1'b0, 32'h0000_0100, 128'd0, 16'h0000, rd);
    chk("zero_strobe", rd, P_PART);

    // Back-pressure: response held five cycles; a second request waits.
    rv[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0100; rsp_r[0] = 1'b0;
    step();
    step();
    chk("bp_not_yet", 128'(rsp_v[0]), 128'd0);
    step();
    chk("bp_first_valid", 128'(rsp_v[0]), 128'd1);
    held = rsp_d[0];
    chk("bp_data", held, P_PART);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 128'(rsp_v[0]), 128'd1);
      chk("bp_hold_data", rsp_d[0], held);
      chk("bp_hold_ready", 128'(rr[0]), 128'd0);
    end
    rsp_r[0] = 1'b1;
    step();
    chk("bp_released", 128'(rsp_v[0]), 128'd0);
    chk("bp_ready_back", 128'(rr[0]), 128'd1);
    step();
    chk("bp_second_taken", 128'(rr[0]), 128'd0);
    rv[0] = 1'b0;
    step();
    chk("bp_second_wait", 128'(rsp_v[0]), 128'd0);
    step();
    chk("bp_second_valid", 128'(rsp_v[0]), 128'd1);
    chk("bp_second_data", rsp_d[0], P_PART);
    step();
    chk("bp_second_done", 128'(rsp_v[0]), 128'd0);

    // Address wrap: 0x0002_0010 aliases 0x0010 in a 128 KiB array.
    txn(0, 2, 1'b1, 32'h0002_0010, P_WRAP, 16'hFFFF, rd);
    txn(0, 2, 1'b0, 32'h0000_0010, 128'd0, 16'h0000, rd);
    chk("wrap_alias", rd, P_WRAP);

    // Latency sweep on the LATENCY=1 and LATENCY=5 instances.
    txn(1, 1, 1'b1, 32'h0000_0040, P_LAT, 16'hFFFF, rd);
    txn(1, 1, 1'b0, 32'h0000_0040, 128'd0, 16'h0000, rd);
    chk("lat1_data", rd, P_LAT);
    txn(2, 5, 1'b1, 32'h0000_0040, P_LAT, 16'hFFFF, rd);
    txn(2, 5, 1'b0, 32'h0000_0047, 128'd0, 16'h0000, rd);
    chk("lat5_data", rd, P_LAT);

    // Reset one cycle after accepting a write (LATENCY=3): write is dropped.
    txn(3, 3, 1'b1, 32'h0000_0200, P_OLD, 16'hFFFF, rd);
    rv[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h0000_0200; wd[3] = P_NEW; ws[3] = 16'hFFFF;
    step();
    rv[3] = 1'b0;
    rst[3] = 1'b1;
    #1;
    chk("midrst_ready_low", 128'(rr[3]), 128'd0);
    step();
    rst[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("midrst_no_resp", 128'(rsp_v[3]), 128'd0);
      step();
    end
    txn(3, 3, 1'b0, 32'h0000_0200, 128'd0, 16'h0000, rd);
    chk("midrst_old_data", rd, P_OLD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
